// File: rtl/c_hs_pkg.sv
// ----------------------------------------------------------------------------
// c_hs_pkg
// Shared definitions for the drive/free handshake arbiter family.
//
// Contents:
//   DATA_W_DEF  default payload width
//   ST_*        arbiter FSM state encodings (2-bit, legacy-compatible constants)
//   GRANT_NONE  o_grant value while no requester is granted
//   onehot2()   1-bit requester index -> one-hot 2-bit grant vector
// ----------------------------------------------------------------------------
package c_hs_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] GRANT_NONE = 2'b00;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/c_hold_slot.sv
// ----------------------------------------------------------------------------
// c_hold_slot
// One-entry holding register with a full flag for a single requester.
//
// Ports:
//   clk    in   clock, all logic on posedge
//   rst    in   synchronous active-high reset (slot empty)
//   load   in   capture din if the slot is empty; ignored while full
//   clear  in   empty the slot (wins over load in the same cycle)
//   din    in   payload to capture
//   dout   out  held payload
//   full   out  slot currently holds a payload
// ----------------------------------------------------------------------------
module c_hold_slot
    import c_hs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full
);

    logic [DATA_W-1:0] data_reg;
    logic              full_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else if (clear) begin
            // A drive landing on the clear cycle is dropped: the requester
            // has to wait for its free pulse before driving again.
            full_reg <= 1'b0;
        end else if (load && !full_reg) begin
            data_reg <= din;
            full_reg <= 1'b1;
        end
    end

    assign dout = data_reg;
    assign full = full_reg;

endmodule

// File: rtl/c_arb_merge2_32b.sv
// ----------------------------------------------------------------------------
// c_arb_merge2_32b
// 2:1 round-robin arbiter/merger for drive/free handshake channels. Each
// requester owns a one-entry holding slot; one transfer is in flight at a
// time through IDLE -> SEND -> WAIT -> IDLE. All outputs are registered.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_drive0/1, i_data0/1_32 requester drive pulse + payload
//   o_free0/1                one-cycle pulse: slot consumed, may drive again
//   o_driveNext, o_data_32   downstream drive pulse + granted payload
//   i_freeNext               downstream free pulse (honoured only in WAIT)
//   o_grant                  one-hot grantee in SEND/WAIT, 2'b00 in IDLE
//   o_timeout                sticky abort flag (only with C_ARB_TIMEOUT_EN)
//
// Build option: define C_ARB_TIMEOUT_EN to abort a WAIT that sees no
// i_freeNext within TIMEOUT cycles of o_driveNext.
// ----------------------------------------------------------------------------
module c_arb_merge2_32b
    import c_hs_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive0,
    input  logic [DATA_W-1:0] i_data0_32,
    output logic              o_free0,
    input  logic              i_drive1,
    input  logic [DATA_W-1:0] i_data1_32,
    output logic              o_free1,
    output logic              o_driveNext,
    output logic [DATA_W-1:0] o_data_32,
    input  logic              i_freeNext,
    output logic [1:0]        o_grant
`ifdef C_ARB_TIMEOUT_EN
    ,
    output logic              o_timeout
`endif
);

    // ------------------------------------------------------------------
    // Holding slots
    // ------------------------------------------------------------------
    logic [1:0]        drive_vec;
    logic [DATA_W-1:0] data_in   [2];
    logic [DATA_W-1:0] slot_data [2];
    logic [1:0]        slot_full;
    logic [1:0]        slot_clear;

    assign drive_vec  = {i_drive1, i_drive0};
    assign data_in[0] = i_data0_32;
    assign data_in[1] = i_data1_32;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            c_hold_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk   (clk),
                .rst   (rst),
                .load  (drive_vec[gi]),
                .clear (slot_clear[gi]),
                .din   (data_in[gi]),
                .dout  (slot_data[gi]),
                .full  (slot_full[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_reg;
    logic              last_grant_reg;   // index of the last slot served
    logic              grant_idx_reg;    // index of the slot in flight
    logic [1:0]        grant_reg;
    logic              drive_next_reg;
    logic [1:0]        free_reg;
    logic [DATA_W-1:0] data_reg;

    logic pick_valid;
    logic pick_idx;
    logic abort;
    logic done;

    // Round-robin pick: a lone full slot wins outright; on a tie the slot
    // that was not served last goes next.
    always_comb begin
        pick_valid = |slot_full;
        pick_idx   = 1'b0;
        if (slot_full == 2'b11) begin
            pick_idx = ~last_grant_reg;
        end else begin
            pick_idx = slot_full[1];
        end
    end

    // Transfer finishes on the downstream free, or on a timeout abort.
    assign done       = (state_reg == ST_WAIT) && (i_freeNext || abort);
    assign slot_clear = done ? onehot2(grant_idx_reg) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            grant_idx_reg  <= 1'b0;
            grant_reg      <= GRANT_NONE;
            drive_next_reg <= 1'b0;
            free_reg       <= 2'b00;
            data_reg       <= '0;
        end else begin
            drive_next_reg <= 1'b0;
            free_reg       <= 2'b00;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        data_reg       <= slot_data[pick_idx];
                        grant_idx_reg  <= pick_idx;
                        grant_reg      <= onehot2(pick_idx);
                        drive_next_reg <= 1'b1;
                        state_reg      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        free_reg       <= onehot2(grant_idx_reg);
                        last_grant_reg <= grant_idx_reg;
                        grant_reg      <= GRANT_NONE;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_driveNext = drive_next_reg;
    assign o_data_32   = data_reg;
    assign o_grant     = grant_reg;
    assign o_free0     = free_reg[0];
    assign o_free1     = free_reg[1];

    // ------------------------------------------------------------------
    // Optional WAIT timeout
    // ------------------------------------------------------------------
`ifdef C_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_reg;

    // The counter is zero in the o_driveNext cycle and advances every cycle
    // of the transfer, so the abort's free pulse lands exactly TIMEOUT
    // cycles after o_driveNext. A same-cycle i_freeNext beats the abort.
    assign abort = (state_reg == ST_WAIT) && !i_freeNext &&
                   (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (abort) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_reg;
`else
    assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_c_arb_merge2_32b.sv
module tb_c_arb_merge2_32b;
    import c_hs_pkg::*;

`ifdef C_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drive0 = 1'b0;
    logic        drive1 = 1'b0;
    logic [31:0] data0 = '0;
    logic [31:0] data1 = '0;
    logic        free_next = 1'b0;
    logic        free0;
    logic        free1;
    logic        drive_next;
    logic [31:0] data_out;
    logic [1:0]  grant;
`ifdef C_ARB_TIMEOUT_EN
    logic        timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    c_arb_merge2_32b #(
        .DATA_W  (32),
        .TIMEOUT (TB_TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive0    (drive0),
        .i_data0_32  (data0),
        .o_free0     (free0),
        .i_drive1    (drive1),
        .i_data1_32  (data1),
        .o_free1     (free1),
        .o_driveNext (drive_next),
        .o_data_32   (data_out),
        .i_freeNext  (free_next),
        .o_grant     (grant)
`ifdef C_ARB_TIMEOUT_EN
        ,
        .o_timeout   (timeout)
`endif
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; drive0 = 1'b0; drive1 = 1'b0; free_next = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({free0, free1, drive_next} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: free0/free1/driveNext=%b required 000", {free0, free1, drive_next});
        end
        n_checks++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL reset_grant: got %b required 00", grant);
        end
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h required 00000000", data_out);
        end
`ifdef C_ARB_TIMEOUT_EN
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_timeout: got %b required 0", timeout);
        end
`endif
        $display("reset: outputs idle grant=%b data=%h", grant, data_out);
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk); drive0 = 1'b1; data0 = 32'hDEADBEEF;            // t
        @(negedge clk); drive0 = 1'b0;                                   // t+1
        n_checks++;
        if (drive_next !== 1'b0) begin
            n_fail++; $display("FAIL single_early: driveNext=%b at t+1 required 0", drive_next);
        end
        @(negedge clk);                                                  // t+2
        n_checks++;
        if (drive_next !== 1'b1 || data_out !== 32'hDEADBEEF || grant !== 2'b01) begin
            n_fail++; $display("FAIL single_send: driveNext=%b data=%h grant=%b required 1 deadbeef 01",
                               drive_next, data_out, grant);
        end
        @(negedge clk);                                                  // t+3
        n_checks++;
        if (drive_next !== 1'b0 || grant !== 2'b01) begin
            n_fail++; $display("FAIL single_wait: driveNext=%b grant=%b required 0 01", drive_next, grant);
        end
        @(negedge clk);                                                  // t+4
        @(negedge clk); free_next = 1'b1;                                // t+5
        n_checks++;
        if (free0 !== 1'b0) begin
            n_fail++; $display("FAIL single_free_early: free0=%b required 0", free0);
        end
        @(negedge clk); free_next = 1'b0;                                // t+6
        n_checks++;
        if (free0 !== 1'b1 || free1 !== 1'b0 || grant !== 2'b00) begin
            n_fail++; $display("FAIL single_free: free0=%b free1=%b grant=%b required 1 0 00", free0, free1, grant);
        end
        @(negedge clk);                                                  // t+7
        n_checks++;
        if (free0 !== 1'b0 || data_out !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_after: free0=%b data=%h required 0 deadbeef", free0, data_out);
        end
        $display("single: data=%h delivered via slot 0", data_out);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        @(negedge clk); drive0 = 1'b1; data0 = 32'h1111AAAA;
                        drive1 = 1'b1; data1 = 32'h2222BBBB;             // t
        @(negedge clk); drive0 = 1'b0; drive1 = 1'b0;                    // t+1
        @(negedge clk);                                                  // t+2
        n_checks++;
        if (drive_next !== 1'b1 || grant !== 2'b01 || data_out !== 32'h1111AAAA) begin
            n_fail++; $display("FAIL simul_first: driveNext=%b grant=%b data=%h required 1 01 1111aaaa",
                               drive_next, grant, data_out);
        end
        @(negedge clk); free_next = 1'b1;                                // t+3
        @(negedge clk); free_next = 1'b0;                                // t+4
        n_checks++;
        if (free0 !== 1'b1 || free1 !== 1'b0) begin
            n_fail++; $display("FAIL simul_free0: free0=%b free1=%b required 1 0", free0, free1);
        end
        @(negedge clk);                                                  // t+5
        n_checks++;
        if (drive_next !== 1'b1 || grant !== 2'b10 || data_out !== 32'h2222BBBB || free0 !== 1'b0) begin
            n_fail++; $display("FAIL simul_second: driveNext=%b grant=%b data=%h free0=%b required 1 10 2222bbbb 0",
                               drive_next, grant, data_out, free0);
        end
        @(negedge clk); free_next = 1'b1;                                // t+6
        @(negedge clk); free_next = 1'b0;                                // t+7
        n_checks++;
        if (free1 !== 1'b1 || free0 !== 1'b0) begin
            n_fail++; $display("FAIL simul_free1: free0=%b free1=%b required 0 1", free0, free1);
        end
        @(negedge clk);                                                  // t+8
        n_checks++;
        if (free1 !== 1'b0) begin
            n_fail++; $display("FAIL simul_free1_pulse: free1=%b required 0", free1);
        end
        $display("simultaneous: served A then B");
    endtask

    task automatic test_fairness();
        int sent0, sent1, served0, served1, side;
        logic found;
        logic [31:0] exp_data;
        apply_reset();
        @(negedge clk);
        drive0 = 1'b1; data0 = 32'hC0DE0000;
        drive1 = 1'b1; data1 = 32'hC0DE0100;
        sent0 = 1; sent1 = 1; served0 = 0; served1 = 0;
        for (int n = 0; n < 8; n++) begin
            found = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                drive0 = 1'b0; drive1 = 1'b0;
                if (drive_next === 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            side = n % 2;
            exp_data = (side == 0) ? (32'hC0DE0000 | 32'(served0)) : (32'hC0DE0100 | 32'(served1));
            n_checks++;
            if (!found) begin
                n_fail++; $display("FAIL fair_timeout: transfer %0d never issued driveNext", n);
            end
            n_checks++;
            if (grant !== onehot2(side[0]) || data_out !== exp_data) begin
                n_fail++; $display("FAIL fair_order: transfer %0d grant=%b data=%h required %b %h",
                                   n, grant, data_out, onehot2(side[0]), exp_data);
            end
            $display("fairness: transfer %0d grant=%b data=%h", n, grant, data_out);
            if (side == 0) served0++; else served1++;
            @(negedge clk); free_next = 1'b1;
            @(negedge clk); free_next = 1'b0;
            n_checks++;
            if ({free1, free0} !== onehot2(side[0])) begin
                n_fail++; $display("FAIL fair_free: transfer %0d free1/free0=%b required %b",
                                   n, {free1, free0}, onehot2(side[0]));
            end
            // Refill the freed side in the very cycle its free pulse appears.
            if (side == 0 && sent0 < 4) begin
                drive0 = 1'b1; data0 = 32'hC0DE0000 | 32'(sent0); sent0++;
            end else if (side == 1 && sent1 < 4) begin
                drive1 = 1'b1; data1 = 32'hC0DE0100 | 32'(sent1); sent1++;
            end
        end
        @(negedge clk); drive0 = 1'b0; drive1 = 1'b0;
    endtask

    task automatic test_violations();
        logic seen;
        apply_reset();
        // Second drive while slot 0 is full is dropped.
        @(negedge clk); drive0 = 1'b1; data0 = 32'h0000A001;             // t
        @(negedge clk); data0 = 32'h0000A002;                            // t+1, slot full
        @(negedge clk); drive0 = 1'b0;                                   // t+2
        n_checks++;
        if (drive_next !== 1'b1 || data_out !== 32'h0000A001) begin
            n_fail++; $display("FAIL viol_first: driveNext=%b data=%h required 1 0000a001", drive_next, data_out);
        end
        @(negedge clk); free_next = 1'b1;
        @(negedge clk); free_next = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (drive_next === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL viol_dropped: dropped payload emerged, data=%h required none", data_out);
        end
        $display("violation: second drive dropped, last data=%h", data_out);
        // Stray free in IDLE.
        @(negedge clk); free_next = 1'b1;
        @(negedge clk); free_next = 1'b0;
        n_checks++;
        if ({free1, free0} !== 2'b00 || grant !== 2'b00) begin
            n_fail++; $display("FAIL viol_stray_idle: free=%b grant=%b required 00 00", {free1, free0}, grant);
        end
        // Normal transfer on slot 1, with a stray free during SEND.
        drive1 = 1'b1; data1 = 32'h0000B001;                             // t
        @(negedge clk); drive1 = 1'b0;                                   // t+1
        @(negedge clk); free_next = 1'b1;                                // t+2, SEND
        n_checks++;
        if (drive_next !== 1'b1 || grant !== 2'b10 || data_out !== 32'h0000B001) begin
            n_fail++; $display("FAIL viol_slot1: driveNext=%b grant=%b data=%h required 1 10 0000b001",
                               drive_next, grant, data_out);
        end
        @(negedge clk); free_next = 1'b0;                                // t+3
        @(negedge clk);                                                  // t+4
        n_checks++;
        if (free1 !== 1'b0 || grant !== 2'b10) begin
            n_fail++; $display("FAIL viol_stray_send: free1=%b grant=%b required 0 10", free1, grant);
        end
        free_next = 1'b1;
        @(negedge clk); free_next = 1'b0;
        n_checks++;
        if (free1 !== 1'b1) begin
            n_fail++; $display("FAIL viol_free1: free1=%b required 1", free1);
        end
        $display("violation: stray frees ignored, slot 1 completed");
    endtask

    task automatic test_rst_in_wait();
        logic seen;
        apply_reset();
        @(negedge clk); drive0 = 1'b1; data0 = 32'h0000D00D;
        @(negedge clk); drive0 = 1'b0;
        @(negedge clk);                                                  // SEND
        @(negedge clk); rst = 1'b1;                                      // WAIT
        @(negedge clk); rst = 1'b0;
        n_checks++;
        if (grant !== 2'b00 || {free1, free0, drive_next} !== 3'b000 || data_out !== 32'h0) begin
            n_fail++; $display("FAIL rstwait_state: grant=%b free=%b driveNext=%b data=%h required 00 00 0 00000000",
                               grant, {free1, free0}, drive_next, data_out);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (free0 === 1'b1 || drive_next === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL rstwait_quiet: activity after reset seen=%b required 0", seen);
        end
        $display("rst in WAIT: returned idle, payload discarded");
    endtask

`ifdef C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic early;
        apply_reset();
        @(negedge clk); drive0 = 1'b1; data0 = 32'h0000E00E;
        @(negedge clk); drive0 = 1'b0;
        @(negedge clk);                                                  // s: driveNext
        n_checks++;
        if (drive_next !== 1'b1) begin
            n_fail++; $display("FAIL to_send: driveNext=%b required 1", drive_next);
        end
        early = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (free0 === 1'b1 || timeout === 1'b1) early = 1'b1;
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_fail++; $display("FAIL to_early: abort before %0d cycles seen=%b required 0", TB_TIMEOUT, early);
        end
        @(negedge clk);                                                  // s+8
        n_checks++;
        if (free0 !== 1'b1 || timeout !== 1'b1 || grant !== 2'b00) begin
            n_fail++; $display("FAIL to_abort: free0=%b timeout=%b grant=%b required 1 1 00", free0, timeout, grant);
        end
        @(negedge clk);
        n_checks++;
        if (free0 !== 1'b0 || timeout !== 1'b1) begin
            n_fail++; $display("FAIL to_sticky: free0=%b timeout=%b required 0 1", free0, timeout);
        end
        $display("timeout: abort after %0d cycles, o_timeout=%b", TB_TIMEOUT, timeout);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_violations();
        test_rst_in_wait();
`ifdef C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
